// File: rtl/bpred_update.sv
// Branch predictor training/resolution: mispredict detection, 2-bit counter mirror,
// victim selection and a one-deep pending write to the prediction table.
// Optional stat counters are compiled in when BPRED_STATS_EN is defined.
module bpred_update #(
    parameter int Psize = 5,
    parameter int NENT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     resolve_valid,
    output logic                     resolve_ready,
    input  logic [Psize-1:0]         resolve_pc,
    input  logic                     resolve_taken,
    input  logic [Psize-1:0]         resolve_target,
    input  logic                     pred_taken,
    input  logic [Psize-1:0]         pred_target,
    output logic                     mispredict,
    output logic [Psize-1:0]         redirect_pc,
    output logic                     wr_en,
    input  logic                     wr_ready,
    output logic [$clog2(NENT)-1:0]  wr_idx,
    output logic                     wr_valid,
    output logic [Psize-1:0]         wr_pc,
    output logic [Psize-1:0]         wr_target
`ifdef BPRED_STATS_EN
    ,
    output logic [15:0]              stat_branches,
    output logic [15:0]              stat_mispredicts
`endif
);
    localparam int IDXW = $clog2(NENT);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  init_idx_q, init_idx_d;
    logic [NENT-1:0]  alloc_q, alloc_d;
    logic [Psize-1:0] tag_q [NENT];
    logic [Psize-1:0] tag_d [NENT];
    logic [Psize-1:0] tgt_q [NENT];
    logic [Psize-1:0] tgt_d [NENT];
    logic [1:0]       ctr_q [NENT];
    logic [1:0]       ctr_d [NENT];
    logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             pend_v_q, pend_v_d;
    logic [IDXW-1:0]  pend_idx_q, pend_idx_d;
    logic             pend_valid_q, pend_valid_d;
    logic [Psize-1:0] pend_pc_q, pend_pc_d;
    logic [Psize-1:0] pend_tgt_q, pend_tgt_d;

    logic             mispredict_q, mispredict_d;
    logic [Psize-1:0] redirect_pc_q, redirect_pc_d;

    logic             accept;
    logic             mis;
    logic [NENT-1:0]  hit_vec;
    logic             hit;
    logic [IDXW-1:0]  hit_idx;
    logic             free_any;
    logic [IDXW-1:0]  free_idx;
    logic [IDXW-1:0]  victim;
    logic [1:0]       new_ctr;

    generate
        for (genvar gi = 0; gi < NENT; gi++) begin : g_hit
            assign hit_vec[gi] = alloc_q[gi] && (tag_q[gi] == resolve_pc);
        end
    endgenerate

    always_comb begin
        hit      = |hit_vec;
        hit_idx  = '0;
        for (int i = 0; i < NENT; i++) begin
            if (hit_vec[i]) hit_idx = IDXW'(i);
        end
        // Scan downward so the lowest free index wins.
        free_any = ~&alloc_q;
        free_idx = '0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (!alloc_q[i]) free_idx = IDXW'(i);
        end
    end

    assign mis = (pred_taken != resolve_taken) ||
                 (pred_taken && resolve_taken && (pred_target != resolve_target));

    assign resolve_ready = !reset && (state_q == RUN) && (!pend_v_q || wr_ready);
    assign accept        = resolve_valid && resolve_ready;

    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        alloc_d       = alloc_q;
        tag_d         = tag_q;
        tgt_d         = tgt_q;
        ctr_d         = ctr_q;
        rr_ptr_d      = rr_ptr_q;
        pend_v_d      = pend_v_q;
        pend_idx_d    = pend_idx_q;
        pend_valid_d  = pend_valid_q;
        pend_pc_d     = pend_pc_q;
        pend_tgt_d    = pend_tgt_q;
        mispredict_d  = 1'b0;
        redirect_pc_d = '0;
        victim        = '0;
        new_ctr       = '0;

        case (state_q)
            INIT: begin
                if (wr_ready) begin
                    if (init_idx_q == IDXW'(NENT - 1)) begin
                        state_d    = RUN;
                        init_idx_d = '0;
                    end else begin
                        init_idx_d = init_idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (pend_v_q && wr_ready) pend_v_d = 1'b0;
                if (accept) begin
                    mispredict_d  = mis;
                    redirect_pc_d = mis ? (resolve_taken ? resolve_target : resolve_pc) : '0;
                    if (hit) begin
                        if (resolve_taken) begin
                            new_ctr             = (ctr_q[hit_idx] == 2'd3) ? 2'd3 : ctr_q[hit_idx] + 2'd1;
                            tgt_d[hit_idx]      = resolve_target;
                        end else begin
                            new_ctr             = (ctr_q[hit_idx] == 2'd0) ? 2'd0 : ctr_q[hit_idx] - 2'd1;
                        end
                        ctr_d[hit_idx] = new_ctr;
                        if (new_ctr == 2'd0) alloc_d[hit_idx] = 1'b0;
                        pend_v_d     = 1'b1;
                        pend_idx_d   = hit_idx;
                        pend_valid_d = new_ctr[1];
                        pend_pc_d    = tag_q[hit_idx];
                        pend_tgt_d   = resolve_taken ? resolve_target : tgt_q[hit_idx];
                    end else if (resolve_taken) begin
                        if (free_any) begin
                            victim = free_idx;
                        end else begin
                            victim   = rr_ptr_q;
                            rr_ptr_d = rr_ptr_q + 1'b1;
                        end
                        alloc_d[victim] = 1'b1;
                        tag_d[victim]   = resolve_pc;
                        tgt_d[victim]   = resolve_target;
                        ctr_d[victim]   = 2'd2;
                        pend_v_d        = 1'b1;
                        pend_idx_d      = victim;
                        pend_valid_d    = 1'b1;
                        pend_pc_d       = resolve_pc;
                        pend_tgt_d      = resolve_target;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT;
            init_idx_q    <= '0;
            alloc_q       <= '0;
            rr_ptr_q      <= '0;
            pend_v_q      <= 1'b0;
            pend_idx_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= '0;
            pend_tgt_q    <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            for (int i = 0; i < NENT; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            alloc_q       <= alloc_d;
            rr_ptr_q      <= rr_ptr_d;
            pend_v_q      <= pend_v_d;
            pend_idx_q    <= pend_idx_d;
            pend_valid_q  <= pend_valid_d;
            pend_pc_q     <= pend_pc_d;
            pend_tgt_q    <= pend_tgt_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            for (int i = 0; i < NENT; i++) begin
                tag_q[i] <= tag_d[i];
                tgt_q[i] <= tgt_d[i];
                ctr_q[i] <= ctr_d[i];
            end
        end
    end

    // Outputs are forced quiet while reset is held, even before the first reset edge.
    always_comb begin
        mispredict  = !reset && mispredict_q;
        redirect_pc = reset ? '0 : redirect_pc_q;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_valid    = 1'b0;
        wr_pc       = '0;
        wr_target   = '0;
        if (!reset) begin
            if (state_q == INIT) begin
                wr_en  = 1'b1;
                wr_idx = init_idx_q;
            end else begin
                wr_en     = pend_v_q;
                wr_idx    = pend_idx_q;
                wr_valid  = pend_valid_q;
                wr_pc     = pend_pc_q;
                wr_target = pend_tgt_q;
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic [15:0] stat_br_q, stat_br_d;
    logic [15:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (accept && (stat_br_q != 16'hFFFF)) stat_br_d = stat_br_q + 16'd1;
        if (accept && mis && (stat_mp_q != 16'hFFFF)) stat_mp_d = stat_mp_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_bpred_update.sv
// Directed self-checking bench for bpred_update (Psize=5, NENT=2).
module tb_bpred_update;
    logic       clk = 1'b0;
    logic       reset;
    logic       resolve_valid;
    logic       resolve_ready;
    logic [4:0] resolve_pc;
    logic       resolve_taken;
    logic [4:0] resolve_target;
    logic       pred_taken;
    logic [4:0] pred_target;
    logic       mispredict;
    logic [4:0] redirect_pc;
    logic       wr_en;
    logic       wr_ready;
    logic [0:0] wr_idx;
    logic       wr_valid;
    logic [4:0] wr_pc;
    logic [4:0] wr_target;

    int errors = 0;
    int checks = 0;

    bpred_update #(.Psize(5), .NENT(2)) dut (
        .clk(clk), .reset(reset),
        .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
        .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .pred_taken(pred_taken),
        .pred_target(pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_idx(wr_idx), .wr_valid(wr_valid), .wr_pc(wr_pc),
        .wr_target(wr_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] pc, input logic tk,
                         input logic [4:0] tgt, input logic pt, input logic [4:0] ptgt);
        resolve_valid  = v;
        resolve_pc     = pc;
        resolve_taken  = tk;
        resolve_target = tgt;
        pred_taken     = pt;
        pred_target    = ptgt;
        #1;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [0:0] idx,
                            input logic vld, input logic [4:0] pc, input logic [4:0] tgt);
        check({tag, "_wr_en"}, 32'(wr_en), 32'(en));
        if (en) begin
            check({tag, "_wr_idx"}, 32'(wr_idx), 32'(idx));
            check({tag, "_wr_valid"}, 32'(wr_valid), 32'(vld));
            check({tag, "_wr_pc"}, 32'(wr_pc), 32'(pc));
            check({tag, "_wr_target"}, 32'(wr_target), 32'(tgt));
        end
    endtask

    task automatic check_mp(input string tag, input logic mp, input logic [4:0] rpc);
        check({tag, "_mispredict"}, 32'(mispredict), 32'(mp));
        if (mp) check({tag, "_redirect"}, 32'(redirect_pc), 32'(rpc));
    endtask

    initial begin
        reset    = 1'b1;
        wr_ready = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        repeat (3) tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_ready", 32'(resolve_ready), 32'd0);
        check("rst_mispredict", 32'(mispredict), 32'd0);

        // INIT clears both entries, RUN on the third cycle
        reset = 1'b0;
        #1;
        check("init0_ready", 32'(resolve_ready), 32'd0);
        check_wr("init0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        check("init1_ready", 32'(resolve_ready), 32'd0);
        check_wr("init1", 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        check("run_ready", 32'(resolve_ready), 32'd1);
        check("run_wr_en", 32'(wr_en), 32'd0);

        // Taken miss with not-taken prediction
        drive(1'b1, 5'd28, 1'b1, 5'd5, 1'b0, 5'd0);
        tick();
        check_mp("alloc28", 1'b1, 5'd5);
        check_wr("alloc28", 1'b1, 1'b0, 1'b1, 5'd28, 5'd5);

        // Two not-taken hits: ctr 2->1->0, entry freed
        drive(1'b1, 5'd28, 1'b0, 5'd0, 1'b1, 5'd5);
        check("nt1_ready", 32'(resolve_ready), 32'd1);
        tick();
        check_mp("nt1", 1'b1, 5'd28);
        check_wr("nt1", 1'b1, 1'b0, 1'b0, 5'd28, 5'd5);
        tick();
        check_mp("nt2", 1'b1, 5'd28);
        check_wr("nt2", 1'b1, 1'b0, 1'b0, 5'd28, 5'd5);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        check_mp("idle", 1'b0, 5'd0);
        check("idle_wr_en", 32'(wr_en), 32'd0);

        // Fill both free entries, then round-robin replacement
        drive(1'b1, 5'd28, 1'b1, 5'd5, 1'b1, 5'd5);
        tick();
        check_mp("fill28", 1'b0, 5'd0);
        check_wr("fill28", 1'b1, 1'b0, 1'b1, 5'd28, 5'd5);
        drive(1'b1, 5'd30, 1'b1, 5'd7, 1'b1, 5'd7);
        tick();
        check_wr("fill30", 1'b1, 1'b1, 1'b1, 5'd30, 5'd7);
        drive(1'b1, 5'd12, 1'b1, 5'd3, 1'b0, 5'd0);
        tick();
        check_mp("rr12", 1'b1, 5'd3);
        check_wr("rr12", 1'b1, 1'b0, 1'b1, 5'd12, 5'd3);
        drive(1'b1, 5'd14, 1'b1, 5'd9, 1'b1, 5'd9);
        tick();
        check_mp("rr14", 1'b0, 5'd0);
        check_wr("rr14", 1'b1, 1'b1, 1'b1, 5'd14, 5'd9);

        // Target mismatch on a taken hit, then a correct prediction
        drive(1'b1, 5'd12, 1'b1, 5'd5, 1'b1, 5'd4);
        tick();
        check_mp("tgtmis", 1'b1, 5'd5);
        check_wr("tgtmis", 1'b1, 1'b0, 1'b1, 5'd12, 5'd5);
        drive(1'b1, 5'd12, 1'b1, 5'd5, 1'b1, 5'd5);
        tick();
        check_mp("tgtok", 1'b0, 5'd0);
        check_wr("tgtok", 1'b1, 1'b0, 1'b1, 5'd12, 5'd5);

        // Table back-pressure for three cycles
        wr_ready = 1'b0;
        drive(1'b1, 5'd14, 1'b0, 5'd0, 1'b1, 5'd9);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 32'(resolve_ready), 32'd0);
            check_wr("stall", 1'b1, 1'b0, 1'b1, 5'd12, 5'd5);
            tick();
            check("stall_mispredict", 32'(mispredict), 32'd0);
        end
        wr_ready = 1'b1;
        #1;
        check("resume_ready", 32'(resolve_ready), 32'd1);
        tick();
        check_mp("resume", 1'b1, 5'd14);
        check_wr("resume", 1'b1, 1'b1, 1'b0, 5'd14, 5'd9);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        check_mp("drain", 1'b0, 5'd0);
        check("drain_wr_en", 32'(wr_en), 32'd0);

        // Reset while a write is pending and a pulse is active
        drive(1'b1, 5'd20, 1'b1, 5'd1, 1'b0, 5'd0);
        tick();
        check_mp("pre_rst", 1'b1, 5'd1);
        reset    = 1'b1;
        wr_ready = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_mispredict", 32'(mispredict), 32'd0);
        check("midrst_ready", 32'(resolve_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_wr("reinit_hold0", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        check_wr("reinit_hold1", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        check("reinit_ready", 32'(resolve_ready), 32'd0);
        wr_ready = 1'b1;
        tick();
        check_wr("reinit_idx1", 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        check("rerun_ready", 32'(resolve_ready), 32'd1);

        // Mirror cleared: not-taken resolve of old PC misses, no write
        drive(1'b1, 5'd28, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        check_mp("cleared", 1'b0, 5'd0);
        check("cleared_wr_en", 32'(wr_en), 32'd0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
